// File: rtl/seven_segment_reader_if.sv
// Multiplexed seven-segment display bus plus the readback results recovered from it.
// master drives the display side; slave is the reader that decodes it.
interface seven_segment_reader_if;
  logic [6:0] segments;
  logic       digit;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       valid;
  logic       seg_error;
  logic       sync_error;

  modport master (
    output segments, digit,
    input  ten_count, unit_count, valid, seg_error, sync_error
  );

  modport slave (
    input  segments, digit,
    output ten_count, unit_count, valid, seg_error, sync_error
  );
endinterface

// File: rtl/seven_segment_reader.sv
// Recovers the two BCD digits shown on a multiplexed seven-segment bus and
// publishes a value once it has been seen unchanged for STABLE_FRAMES frames.
module seven_segment_reader #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  seven_segment_reader_if.slave       bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_FRAMES);

  logic [6:0] s_seg;
  logic       s_dig;
  logic       s_vld;
  logic       prev_dig;
  logic       prev_ok;
  logic [3:0] tens_hold;
  logic       tens_ok;
  logic [7:0] cand;
  logic [3:0] match_cnt;
  logic       pub_ok;
  logic [3:0] ten_r;
  logic [3:0] unit_r;
  logic       valid_r;
  logic       seg_err_r;
  logic       sync_err_r;

  logic [3:0] dec;
  logic       dec_ok;
  logic       sync_fault;
  logic [7:0] frame;
  logic [3:0] next_cnt;
  logic       publish;

  // Pattern bits are ordered g..a; blank is a legal pattern that reads as 4'hF.
  always_comb begin
    dec    = 4'h0;
    dec_ok = 1'b1;
    case (s_seg)
      7'b0111111: dec = 4'd0;
      7'b0000110: dec = 4'd1;
      7'b1011011: dec = 4'd2;
      7'b1001111: dec = 4'd3;
      7'b1100110: dec = 4'd4;
      7'b1101101: dec = 4'd5;
      7'b1111100: dec = 4'd6;
      7'b0000111: dec = 4'd7;
      7'b1111111: dec = 4'd8;
      7'b1100111: dec = 4'd9;
      7'b0000000: dec = 4'hF;
      default:    dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    sync_fault = prev_ok && (s_dig == prev_dig);
    frame      = {tens_hold, dec};
    if (frame == cand)
      next_cnt = (match_cnt >= STABLE) ? STABLE : 4'(match_cnt + 4'd1);
    else
      next_cnt = 4'd1;
    publish = (next_cnt == STABLE) && (!pub_ok || (frame != {ten_r, unit_r}));
  end

  // s_vld marks that s_seg/s_dig hold a real captured sample, so the first
  // edge after reset only captures; prev_ok suppresses the sync check once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_seg      <= 7'd0;
      s_dig      <= 1'b0;
      s_vld      <= 1'b0;
      prev_dig   <= 1'b0;
      prev_ok    <= 1'b0;
      tens_hold  <= 4'd0;
      tens_ok    <= 1'b0;
      cand       <= 8'd0;
      match_cnt  <= 4'd0;
      pub_ok     <= 1'b0;
      ten_r      <= 4'd0;
      unit_r     <= 4'd0;
      valid_r    <= 1'b0;
      seg_err_r  <= 1'b0;
      sync_err_r <= 1'b0;
    end else begin
      s_seg      <= bus.segments;
      s_dig      <= bus.digit;
      s_vld      <= 1'b1;
      valid_r    <= 1'b0;
      seg_err_r  <= 1'b0;
      sync_err_r <= 1'b0;
      if (s_vld) begin
        prev_dig   <= s_dig;
        prev_ok    <= 1'b1;
        seg_err_r  <= !dec_ok;
        sync_err_r <= sync_fault;
        if (!dec_ok || sync_fault) begin
          tens_ok   <= 1'b0;
          match_cnt <= 4'd0;
        end else if (!s_dig) begin
          tens_hold <= dec;
          tens_ok   <= 1'b1;
        end else if (tens_ok) begin
          tens_ok   <= 1'b0;
          cand      <= frame;
          match_cnt <= next_cnt;
          if (publish) begin
            ten_r   <= tens_hold;
            unit_r  <= dec;
            valid_r <= 1'b1;
            pub_ok  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ten_count  = ten_r;
  assign bus.unit_count = unit_r;
  assign bus.valid      = valid_r;
  assign bus.seg_error  = seg_err_r;
  assign bus.sync_error = sync_err_r;

endmodule
